// File: rtl/rv_fetch_queue.sv
// rtl/rv_fetch_queue.sv - pipelined RV32E instruction fetcher with an in-order instruction queue
// Keeps up to MAX_OUTSTANDING requests in flight and drops responses that belong to a flushed stream.
module rv_fetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] NOP_INST        = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] boot_addr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ready,
  input  logic [31:0] instruction,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus_4
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = AW + 2;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_DRAIN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [TW-1:0] tag_rd_q, tag_rd_d;
  logic [TW-1:0] tag_wr_q, tag_wr_d;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   tag_mem   [MAX_OUTSTANDING];

  logic          resp;
  logic          stale_resp;
  logic          enq;
  logic          deq;
  logic [CW-1:0] credit;
  logic [31:0]   pc_tag;

  always_comb begin
    resp       = inst_ready && (outstanding_q != '0);
    stale_resp = resp && (discard_q != '0);
    // Only live requests reserve queue space; stale ones will never be written.
    credit     = count_q + outstanding_q - discard_q;
    inst_req   = (state_q != ST_BOOT) && (outstanding_q < CW'(MAX_OUTSTANDING))
                 && (credit < CW'(DEPTH));
    inst_addr  = redirect_valid ? (redirect_addr & ~32'h3) : fetch_pc_q;
    pc_tag     = tag_mem[tag_rd_q];

    id_valid     = (count_q != '0);
    id_instr     = id_valid ? instr_mem[rd_ptr_q] : NOP_INST;
    id_pc        = id_valid ? pc_mem[rd_ptr_q] : 32'h0;
    id_pc_plus_4 = id_pc + 32'd4;

    enq = resp && !stale_resp && !redirect_valid;
    deq = id_valid && id_ready && !redirect_valid;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (inst_req) begin
      fetch_pc_d = inst_addr + 32'd4;
    end else if (redirect_valid) begin
      fetch_pc_d = redirect_addr & ~32'h3;
    end

    outstanding_d = outstanding_q + CW'(inst_req) - CW'(resp);

    if (redirect_valid) begin
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      // Everything in flight before this edge, minus the one answered now, is stale.
      discard_d = outstanding_q - CW'(resp);
    end else begin
      count_d   = count_q + CW'(enq) - CW'(deq);
      wr_ptr_d  = wr_ptr_q + AW'(enq);
      rd_ptr_d  = rd_ptr_q + AW'(deq);
      discard_d = discard_q - CW'(stale_resp);
    end

    tag_wr_d = tag_wr_q;
    if (inst_req) begin
      tag_wr_d = (tag_wr_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr_q + TW'(1);
    end
    tag_rd_d = tag_rd_q;
    if (resp) begin
      tag_rd_d = (tag_rd_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd_q + TW'(1);
    end

    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   if (redirect_valid && (outstanding_q != '0)) state_d = ST_DRAIN;
      ST_DRAIN: if (!redirect_valid && (discard_d == '0)) state_d = ST_RUN;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      fetch_pc_q    <= boot_addr & ~32'h3;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
    end
  end

  // Storage arrays carry no reset; occupancy counters decide what is valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr_q] <= instruction;
      pc_mem[wr_ptr_q]    <= pc_tag;
    end
    if (inst_req) begin
      tag_mem[tag_wr_q] <= inst_addr;
    end
  end

endmodule
